bluetooth_tx: RTL and testbench

- UART transmitter (8N1, LSB first) driving the TX pin of the Bluetooth module. It is the counterpart of the fan board's Bluetooth receive path.
- Bytes are queued through a valid/ready write port into a small internal FIFO, then serialized back-to-back with no idle gap.
- Used to send fan status and acknowledgements (speed level, mode) back to the phone app.

---
 rtl/bluetooth_tx.sv | 169 ++++++++++++++++
 tb/tb_bluetooth_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bluetooth_tx.sv
// bluetooth_tx: 8N1 UART transmitter (LSB first) feeding the Bluetooth module TX pin.
// Bytes are queued through a valid/ready write port into a small circular FIFO
// and serialized back-to-back with no idle gap between frames.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   in_valid    byte-write request
//   in_data     byte to queue
//   in_ready    FIFO can accept a byte this cycle (registered)
//   TX          serial line, idle high (registered)
//   tx_busy     a frame is on the line (START, DATA or STOP)
//   tx_done     one-cycle pulse when a stop bit completes
//   fifo_count  bytes queued, excluding the byte being sent
module bluetooth_tx #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             TX,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic              push_c;
    logic              pop_c;
    logic              bit_end_c;
    logic [CNT_W-1:0]  count_nxt_c;

    // Handshake and pop decisions; pop uses the pre-edge count, so a byte
    // pushed into an empty FIFO is popped one edge later.
    assign bit_end_c = (baud_cnt == BAUD_LAST);
    assign push_c    = in_valid & in_ready;
    assign pop_c     = (fifo_count != '0) &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_end_c));

    // Next occupancy; push and pop on the same edge cancel.
    always_comb begin
        count_nxt_c = fifo_count;
        case ({push_c, pop_c})
            2'b10:   count_nxt_c = fifo_count + CNT_W'(1);
            2'b01:   count_nxt_c = fifo_count - CNT_W'(1);
            default: count_nxt_c = fifo_count;
        endcase
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_nxt_c;
            in_ready   <= (count_nxt_c < CNT_FULL);
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= in_data;
    end

    // Frame FSM: START, 8 DATA bits, STOP, each CLKS_PER_BIT cycles long.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    TX      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop_c) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        TX       <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        TX       <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            TX    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            // Next bit is shift[1] before the shift lands.
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            TX      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        if (pop_c) begin
                            // Chain straight into the next start bit.
                            shift <= mem[rd_ptr];
                            TX    <= 1'b0;
                            state <= S_START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    TX      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Directed bench for bluetooth_tx at CLKS_PER_BIT=16: a line decoder collects
// frames and stop-bit pulses, and each test compares them with hand-computed values.
module tb_bluetooth_tx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;
    localparam int          FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          TX;
    logic          tx_busy;
    logic          tx_done;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int frame_err = 0;
    int rx_q[$];
    int fall_q[$];
    int done_q[$];
    logic abort;
    logic [7:0] mon_byte;
    logic mon_start;
    logic mon_stop;

    bluetooth_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .TX(TX), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : -1;
    endfunction
    function automatic int fall_at(input int i);
        return (i < fall_q.size()) ? fall_q[i] : -100000;
    endfunction
    function automatic int done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : -1;
    endfunction

    task automatic clear_q();
        rx_q.delete();
        fall_q.delete();
        done_q.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (reset_n !== 1'b1) abort = 1'b1;
        end
    endtask

    // Line decoder: samples each bit near its middle, starting from the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && TX === 1'b0) begin
                abort = 1'b0;
                fall_q.push_back(cyc);
                mon_wait(CPB / 2 - 1);
                mon_start = TX;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB);
                    mon_byte[i] = TX;
                end
                mon_wait(CPB);
                mon_stop = TX;
                if (!abort) begin
                    rx_q.push_back(int'(mon_byte));
                    if (mon_start !== 1'b0 || mon_stop !== 1'b1) frame_err++;
                end
            end
        end
    end

    always @(negedge clk) if (tx_done === 1'b1) done_q.push_back(cyc);

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int bad;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_done", tx_done, 0);
        reset_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (TX !== 1'b1) bad++;
        end
        check("idle_tx_low_cycles", bad, 0);
        check("idle_ready", in_ready, 1);

        // Single byte 0x41
        clear_q();
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 8'h41;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'hFF;
        check("sb_count_after_accept", fifo_count, 1);
        check("sb_tx_still_high", TX, 1);
        @(negedge clk);
        check("sb_tx_low_latency", TX, 0);
        check("sb_busy", tx_busy, 1);
        check("sb_count_after_pop", fifo_count, 0);
        wait_cyc(c0 + 2 + FRAME + 20);
        check("sb_fall_cycle", fall_at(0), c0 + 2);
        check("sb_byte", rx_at(0), 32'h41);
        check("sb_frames", rx_q.size(), 1);
        check("sb_done_delta", done_at(0) - fall_at(0), FRAME);
        check("sb_busy_after", tx_busy, 0);
        check("sb_tx_after", TX, 1);

        // Back-to-back 0x55, 0xA3, 0x00
        clear_q();
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        check("b2b_count1", fifo_count, 1);
        in_data = 8'hA3;
        @(negedge clk);
        in_data = 8'h00;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'hEE;
        check("b2b_count2", fifo_count, 2);
        wait_cyc(c0 + 2 + FRAME);
        check("b2b_done1_pulse", tx_done, 1);
        check("b2b_count_after_pop1", fifo_count, 1);
        wait_cyc(c0 + 2 + 2 * FRAME);
        check("b2b_count_after_pop2", fifo_count, 0);
        wait_cyc(c0 + 2 + 3 * FRAME + 20);
        check("b2b_byte0", rx_at(0), 32'h55);
        check("b2b_byte1", rx_at(1), 32'hA3);
        check("b2b_byte2", rx_at(2), 32'h00);
        check("b2b_frames", rx_q.size(), 3);
        check("b2b_gap", fall_at(1) - fall_at(0), FRAME);
        check("b2b_done1", done_at(0) - fall_at(0), FRAME);
        check("b2b_done2", done_at(1) - fall_at(0), 2 * FRAME);
        check("b2b_done3", done_at(2) - fall_at(0), 3 * FRAME);

        // FIFO full: 0x10..0x13 accepted, 0x14 refused
        clear_q();
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cyc(c0 + 30);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        check("full_count", fifo_count, 4);
        check("full_ready", in_ready, 0);
        in_data = 8'h14;
        @(negedge clk);
        check("full_count_hold", fifo_count, 4);
        in_valid = 1'b0;
        wait_cyc(c0 + 2 + 5 * FRAME + 20);
        check("full_frames", rx_q.size(), 5);
        check("full_b0", rx_at(0), 32'hC3);
        check("full_b1", rx_at(1), 32'h10);
        check("full_b2", rx_at(2), 32'h11);
        check("full_b3", rx_at(3), 32'h12);
        check("full_b4", rx_at(4), 32'h13);
        check("full_ready_after", in_ready, 1);

        // Push on the STOP-final edge that pops, with two bytes queued
        clear_q();
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_data = 8'h3C;
        @(negedge clk);
        in_data = 8'h81;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cyc(c0 + 1 + FRAME);
        check("pp_count_before", fifo_count, 2);
        in_valid = 1'b1; in_data = 8'hE7;
        @(negedge clk);
        in_valid = 1'b0;
        check("pp_done_edge", tx_done, 1);
        check("pp_count_after", fifo_count, 2);
        wait_cyc(c0 + 2 + 4 * FRAME + 20);
        check("pp_frames", rx_q.size(), 4);
        check("pp_b2", rx_at(2), 32'h81);
        check("pp_last", rx_at(3), 32'hE7);

        // Reset during DATA bit 3 of 0xFF, with 0x77 still queued
        clear_q();
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cyc(c0 + 2 + 4 * CPB + CPB / 2);
        check("mr_tx_bit3", TX, 1);
        check("mr_count_before", fifo_count, 1);
        check("mr_busy_before", tx_busy, 1);
        #3 reset_n = 1'b0;
        #1;
        check("mr_tx_async", TX, 1);
        check("mr_count_async", fifo_count, 0);
        check("mr_busy_async", tx_busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_q();
        repeat (300) @(negedge clk);
        check("mr_no_residual_fall", fall_q.size(), 0);
        check("mr_no_residual_done", done_q.size(), 0);
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cyc(c0 + 2 + FRAME + 20);
        check("mr_new_byte", rx_at(0), 32'h0F);
        check("mr_new_frames", rx_q.size(), 1);
        check("mr_new_done", done_at(0) - fall_at(0), FRAME);

        check("frame_format_errors", frame_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
